// File: rtl/fp_div_result_stage.sv
// fp_div_result_stage
// Registered back-end for the combinational binary32 divider. Stage 1 captures
// the operands, the raw quotient word and the operand classes; stage 2 holds
// the IEEE-754 patched result and exception flags for the writeback consumer.
// Both stages form an elastic pipeline: two entries, one result per cycle.

module fp_div_result_stage #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [DATA_WIDTH-1:0] op_a,
  input  logic [DATA_WIDTH-1:0] op_b,
  input  logic [DATA_WIDTH-1:0] div_raw,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic [3:0]            m_flags,
  output logic                  busy
);

  typedef enum logic [1:0] {
    CLS_ZERO = 2'd0,
    CLS_NORM = 2'd1,
    CLS_INF  = 2'd2,
    CLS_NAN  = 2'd3
  } op_class_e;

  // Subnormals are flushed, so any zero exponent is treated as a zero operand.
  function automatic op_class_e classify(input logic [DATA_WIDTH-2:0] mag);
    op_class_e cls;
    cls = CLS_NORM;
    if (mag[30:23] == 8'h00) begin
      cls = CLS_ZERO;
    end else if (mag[30:23] == 8'hFF) begin
      cls = (mag[22:0] == 23'd0) ? CLS_INF : CLS_NAN;
    end
    return cls;
  endfunction

  // The result sign comes from the operands, so the divider's own sign bit is ignored.
  logic unused_raw_sign;
  assign unused_raw_sign = div_raw[DATA_WIDTH-1];

  logic                  s1_valid_q, s1_valid_d;
  logic [DATA_WIDTH-1:0] s1_a_q, s1_a_d;
  logic [DATA_WIDTH-1:0] s1_b_q, s1_b_d;
  logic [DATA_WIDTH-2:0] s1_raw_q, s1_raw_d;
  op_class_e             s1_cls_a_q, s1_cls_a_d;
  op_class_e             s1_cls_b_q, s1_cls_b_d;

  logic                  m_valid_q, m_valid_d;
  logic [DATA_WIDTH-1:0] m_data_q, m_data_d;
  logic [3:0]            m_flags_q, m_flags_d;

  logic                  s1_advance;
  logic                  s1_load;

  logic                  res_sign;
  logic [23:0]           mant_a;
  logic [23:0]           mant_b;
  logic                  mant_lt;
  logic signed [10:0]    exp_res;
  logic [DATA_WIDTH-1:0] res_data;
  logic [3:0]            res_flags;

  // Handshake: S1 drains whenever the output slot is empty or being consumed,
  // and may reload in that same cycle.
  always_comb begin
    s1_advance = s1_valid_q && (!m_valid_q || m_ready);
    s_ready    = !s1_valid_q || s1_advance;
    s1_load    = s_valid && s_ready;
    m_valid    = m_valid_q;
    m_data     = m_data_q;
    m_flags    = m_flags_q;
    busy       = s1_valid_q || m_valid_q;
  end

  // Stage 1 next state: capture operands, raw quotient and operand classes.
  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_a_d     = s1_a_q;
    s1_b_d     = s1_b_q;
    s1_raw_d   = s1_raw_q;
    s1_cls_a_d = s1_cls_a_q;
    s1_cls_b_d = s1_cls_b_q;
    if (s1_load) begin
      s1_valid_d = 1'b1;
      s1_a_d     = op_a;
      s1_b_d     = op_b;
      s1_raw_d   = div_raw[DATA_WIDTH-2:0];
      s1_cls_a_d = classify(op_a[DATA_WIDTH-2:0]);
      s1_cls_b_d = classify(op_b[DATA_WIDTH-2:0]);
    end else if (s1_advance) begin
      s1_valid_d = 1'b0;
    end
  end

  // Result patching: special operands first, then exponent range, else pass the raw quotient.
  always_comb begin
    res_sign  = s1_a_q[31] ^ s1_b_q[31];
    mant_a    = {1'b1, s1_a_q[22:0]};
    mant_b    = {1'b1, s1_b_q[22:0]};
    mant_lt   = (mant_a < mant_b);
    exp_res   = $signed({3'b000, s1_a_q[30:23]}) - $signed({3'b000, s1_b_q[30:23]})
              + 11'sd127 - $signed({10'd0, mant_lt});
    res_data  = {res_sign, s1_raw_q};
    res_flags = 4'b0000;
    if ((s1_cls_a_q == CLS_NAN) || (s1_cls_b_q == CLS_NAN) ||
        ((s1_cls_a_q == CLS_ZERO) && (s1_cls_b_q == CLS_ZERO)) ||
        ((s1_cls_a_q == CLS_INF) && (s1_cls_b_q == CLS_INF))) begin
      res_data  = 32'h7FC0_0000;
      res_flags = 4'b1000;
    end else if ((s1_cls_a_q == CLS_NORM) && (s1_cls_b_q == CLS_ZERO)) begin
      res_data  = {res_sign, 8'hFF, 23'd0};
      res_flags = 4'b0100;
    end else if (s1_cls_a_q == CLS_INF) begin
      res_data  = {res_sign, 8'hFF, 23'd0};
    end else if ((s1_cls_b_q == CLS_INF) || (s1_cls_a_q == CLS_ZERO)) begin
      res_data  = {res_sign, 31'd0};
    end else if (exp_res >= 11'sd255) begin
      res_data  = {res_sign, 8'hFF, 23'd0};
      res_flags = 4'b0010;
    end else if (exp_res <= 11'sd0) begin
      res_data  = {res_sign, 31'd0};
      res_flags = 4'b0001;
    end
  end

  // Stage 2 next state: load on S1 advance, otherwise hold until consumed.
  always_comb begin
    m_valid_d = m_valid_q;
    m_data_d  = m_data_q;
    m_flags_d = m_flags_q;
    if (s1_advance) begin
      m_valid_d = 1'b1;
      m_data_d  = res_data;
      m_flags_d = res_flags;
    end else if (m_ready) begin
      m_valid_d = 1'b0;
    end
  end

  // Pipeline registers; reset discards both entries immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_a_q     <= '0;
      s1_b_q     <= '0;
      s1_raw_q   <= '0;
      s1_cls_a_q <= CLS_ZERO;
      s1_cls_b_q <= CLS_ZERO;
      m_valid_q  <= 1'b0;
      m_data_q   <= '0;
      m_flags_q  <= 4'b0000;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_a_q     <= s1_a_d;
      s1_b_q     <= s1_b_d;
      s1_raw_q   <= s1_raw_d;
      s1_cls_a_q <= s1_cls_a_d;
      s1_cls_b_q <= s1_cls_b_d;
      m_valid_q  <= m_valid_d;
      m_data_q   <= m_data_d;
      m_flags_q  <= m_flags_d;
    end
  end

endmodule

// File: tb/tb_fp_div_result_stage.sv
// tb_fp_div_result_stage
// Scoreboard bench: accepted inputs push the reference result, an output
// monitor pops and compares on every m_valid && m_ready transfer.

module tb_fp_div_result_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        s_valid;
  logic        s_ready;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic [31:0] div_raw;
  logic        m_valid;
  logic        m_ready;
  logic [31:0] m_data;
  logic [3:0]  m_flags;
  logic        busy;

  int          checks = 0;
  int          errors = 0;
  int          out_count = 0;
  logic [35:0] exp_q[$];

  logic        prev_stall = 1'b0;
  logic [31:0] prev_data;
  logic [3:0]  prev_flags;

  fp_div_result_stage #(.DATA_WIDTH(32)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .op_a    (op_a),
    .op_b    (op_b),
    .div_raw (div_raw),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .m_data  (m_data),
    .m_flags (m_flags),
    .busy    (busy)
  );

  // Free-running clock, period 10.
  always #5 clk = ~clk;

  // Operand class: 0 zero, 1 normal, 2 infinity, 3 NaN.
  function automatic int classOf(input logic [31:0] x);
    if (x[30:23] == 8'd0) return 0;
    if (x[30:23] == 8'hFF) return (x[22:0] == 23'd0) ? 2 : 3;
    return 1;
  endfunction

  // Reference quotient/flags from the IEEE special-case rules; returns {flags, data}.
  function automatic logic [35:0] refModel(input logic [31:0] a, input logic [31:0] b,
                                           input logic [31:0] raw);
    int ca;
    int cb;
    int e;
    logic s;
    ca = classOf(a);
    cb = classOf(b);
    s  = a[31] ^ b[31];
    if (ca == 3 || cb == 3 || (ca == 0 && cb == 0) || (ca == 2 && cb == 2))
      return {4'b1000, 32'h7FC00000};
    if (ca == 1 && cb == 0) return {4'b0100, s, 8'hFF, 23'd0};
    if (ca == 2) return {4'b0000, s, 8'hFF, 23'd0};
    if (cb == 2 || ca == 0) return {4'b0000, s, 31'd0};
    e = int'(a[30:23]) - int'(b[30:23]) + 127 - ((a[22:0] < b[22:0]) ? 1 : 0);
    if (e >= 255) return {4'b0010, s, 8'hFF, 23'd0};
    if (e <= 0) return {4'b0001, s, 31'd0};
    return {4'b0000, s, raw[30:0]};
  endfunction

  // Random operand biased toward zeros, specials and exponent extremes.
  function automatic logic [31:0] randOperand();
    logic       s;
    logic [22:0] f;
    s = 1'($urandom_range(0, 1));
    f = 23'($urandom);
    case ($urandom_range(0, 11))
      0:       return {s, 8'd0, 23'd0};
      1:       return {s, 8'd0, f | 23'd1};
      2:       return {s, 8'hFF, 23'd0};
      3:       return {s, 8'hFF, f | 23'd1};
      4:       return {s, 8'($urandom_range(250, 254)), f};
      5:       return {s, 8'($urandom_range(1, 4)), f};
      default: return {s, 8'($urandom_range(1, 254)), f};
    endcase
  endfunction

  function automatic logic [31:0] randNormal();
    return {1'($urandom_range(0, 1)), 8'($urandom_range(100, 150)), 23'($urandom)};
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Present one input from the posedge+1 phase, hold it until accepted, return at posedge+1.
  task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b, input logic [31:0] raw);
    int waited;
    waited = 0;
    op_a    = a;
    op_b    = b;
    div_raw = raw;
    s_valid = 1'b1;
    forever begin
      @(negedge clk);
      if (s_ready) break;
      waited++;
      if (waited > 200) begin
        checks++;
        errors++;
        $display("[TB] FAIL accept_timeout: got no s_ready, expected accept within 200 cycles");
        break;
      end
    end
    @(posedge clk);
    #1;
    s_valid = 1'b0;
  endtask

  // Wait for the scoreboard and pipeline to empty, bounded.
  task automatic drainPipe();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || busy) && n < 200) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 200) begin
      errors++;
      $display("[TB] FAIL drain_timeout: got %0d pending, expected 0", exp_q.size());
    end
    @(posedge clk);
    #1;
  endtask

  // Input-side monitor: every accepted transfer pushes its reference result.
  always @(negedge clk) begin
    if (rst_n && s_valid && s_ready) exp_q.push_back(refModel(op_a, op_b, div_raw));
  end

  // Output-side monitor: compare each transfer and check stability while stalled.
  always @(negedge clk) begin
    logic [35:0] exp;
    if (rst_n && prev_stall) begin
      checkOutput("stall_valid", {31'd0, m_valid}, 32'd1);
      checkOutput("stall_data", m_data, prev_data);
      checkOutput("stall_flags", {28'd0, m_flags}, {28'd0, prev_flags});
    end
    if (rst_n && m_valid && m_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_output: got 0x%08h, expected no output", m_data);
      end else begin
        exp = exp_q.pop_front();
        checkOutput("m_data", m_data, exp[31:0]);
        checkOutput("m_flags", {28'd0, m_flags}, {28'd0, exp[35:32]});
      end
      out_count++;
    end
    prev_stall = rst_n && m_valid && !m_ready;
    prev_data  = m_data;
    prev_flags = m_flags;
  end

  // Global time limit so the run always terminates.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got no completion, expected finish before time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed scenarios followed by randomized traffic with random backpressure.
  initial begin
    int base;
    int low_cnt;
    logic [31:0] held;
    bit done;

    rst_n   = 1'b0;
    s_valid = 1'b0;
    m_ready = 1'b1;
    op_a    = '0;
    op_b    = '0;
    div_raw = '0;
    #12;
    checkOutput("rst_m_valid", {31'd0, m_valid}, 32'd0);
    checkOutput("rst_m_data", m_data, 32'd0);
    checkOutput("rst_m_flags", {28'd0, m_flags}, 32'd0);
    checkOutput("rst_busy", {31'd0, busy}, 32'd0);
    checkOutput("rst_s_ready", {31'd0, s_ready}, 32'd1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Normal divide with latency check.
    applyStimulus(32'h40C00000, 32'h40000000, 32'h40400000);
    @(negedge clk);
    checkOutput("lat_cycle1", {31'd0, m_valid}, 32'd0);
    @(negedge clk);
    checkOutput("lat_cycle2", {31'd0, m_valid}, 32'd1);
    checkOutput("t1_data", m_data, 32'h40400000);
    @(posedge clk);
    #1;
    drainPipe();

    // Specials and range limits.
    applyStimulus(32'h3F800000, 32'h00000000, 32'h12345678);
    applyStimulus(32'h00000000, 32'h00000000, 32'h12345678);
    applyStimulus(32'hFF800000, 32'h40000000, 32'h12345678);
    applyStimulus(32'h7F000000, 32'h00800000, 32'h12345678);
    applyStimulus(32'h00800000, 32'h7F000000, 32'h12345678);
    applyStimulus(32'h80000000, 32'h7FC00001, 32'h12345678);
    drainPipe();

    // Backpressure: six back-to-back inputs, consumer stalled four cycles.
    base    = out_count;
    m_ready = 1'b0;
    fork
      begin
        for (int i = 0; i < 6; i++) applyStimulus(randNormal(), randNormal(), 32'($urandom));
      end
      begin
        repeat (3) @(negedge clk);
        held = m_data;
        checkOutput("bp_s_ready", {31'd0, s_ready}, 32'd0);
        for (int i = 0; i < 3; i++) begin
          @(negedge clk);
          checkOutput("bp_s_ready", {31'd0, s_ready}, 32'd0);
          checkOutput("bp_hold", m_data, held);
        end
        @(posedge clk);
        #1;
        m_ready = 1'b1;
      end
    join
    drainPipe();
    checkOutput("bp_count", 32'(out_count - base), 32'd6);

    // Streaming: 20 inputs with the consumer always ready.
    fork
      begin
        for (int i = 0; i < 20; i++) applyStimulus(randNormal(), randNormal(), 32'($urandom));
      end
      begin
        @(posedge clk);
        base    = out_count;
        low_cnt = 0;
        for (int i = 0; i < 21; i++) begin
          @(negedge clk);
          if (i < 19 && !s_ready) low_cnt++;
        end
        #1;
        checkOutput("stream_s_ready_low", 32'(low_cnt), 32'd0);
        checkOutput("stream_count", 32'(out_count - base), 32'd20);
      end
    join
    drainPipe();

    // Randomized traffic with random gaps and random backpressure.
    done = 1'b0;
    fork
      begin
        for (int i = 0; i < 150; i++) begin
          repeat ($urandom_range(0, 2)) begin
            @(posedge clk);
            #1;
          end
          applyStimulus(randOperand(), randOperand(), 32'($urandom));
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk);
          #1;
          m_ready = ($urandom_range(0, 3) != 0);
        end
        m_ready = 1'b1;
      end
    join
    drainPipe();

    // Reset with both stages full.
    m_ready = 1'b0;
    applyStimulus(randNormal(), randNormal(), 32'($urandom));
    applyStimulus(randNormal(), randNormal(), 32'($urandom));
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("arst_m_valid", {31'd0, m_valid}, 32'd0);
    checkOutput("arst_busy", {31'd0, busy}, 32'd0);
    exp_q.delete();
    @(posedge clk);
    #1;
    rst_n   = 1'b1;
    m_ready = 1'b1;
    @(negedge clk);
    checkOutput("post_rst_s_ready", {31'd0, s_ready}, 32'd1);
    @(posedge clk);
    #1;
    base = out_count;
    applyStimulus(32'h40C00000, 32'h40000000, 32'h40400000);
    drainPipe();
    checkOutput("post_rst_count", 32'(out_count - base), 32'd1);

    checkOutput("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
